// File: rtl/instr_memory_responder.sv
// Memory-side responder for the core's instruction-fetch port.
// A word-streaming loader fills the instruction RAM while the core is held in
// reset; once the load completes the responder serves fetches through a
// registered output that doubles as the IF/DE instruction register.
module instr_memory_responder #(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter logic [31:0] NOP_WORD    = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] instr_memory_addr,
    input  logic        instr_memory_enable,
    input  logic        instr_memory_flush,
    output logic [31:0] instr_memory_data,
    input  logic        load_start,
    input  logic [15:0] load_len,
    input  logic        load_valid,
    input  logic [31:0] load_data,
    output logic        load_ready,
    output logic        core_hold,
    output logic        fetch_fault
);

    localparam int unsigned AW      = $clog2(DEPTH_WORDS);
    localparam logic [31:0] DEPTH32 = 32'(DEPTH_WORDS);

    typedef enum logic [1:0] {StIdle, StLoad, StRun} state_e;

    state_e          state_q;
    logic [AW-1:0]   wptr_q;
    logic [16:0]     cnt_q;
    logic [16:0]     len_q;
    logic [31:0]     mem [DEPTH_WORDS];

    logic            accept;
    logic            last_word;
    logic [16:0]     len_clamped;
    logic            addr_misaligned;
    logic            addr_out_of_range;
    logic [AW-1:0]   rd_idx;

    // Handshake decode, length clamp and fetch address checks.
    always_comb begin
        accept            = (state_q == StLoad) && load_valid && load_ready;
        last_word         = (cnt_q + 17'd1) == len_q;
        // Clamping to the RAM depth keeps wptr from wrapping within a session.
        if ({16'b0, load_len} > DEPTH32) begin
            len_clamped = DEPTH32[16:0];
        end else begin
            len_clamped = {1'b0, load_len};
        end
        addr_misaligned   = instr_memory_addr[1:0] != 2'b00;
        addr_out_of_range = {2'b00, instr_memory_addr[31:2]} >= DEPTH32;
        rd_idx            = instr_memory_addr[AW+1:2];
    end

    // RAM write port: only in LOAD, and never on a reset edge so that a reset
    // mid-load leaves RAM contents untouched.
    always_ff @(posedge clk) begin
        if (reset && accept) begin
            mem[wptr_q] <= load_data;
        end
    end

    // Loader FSM plus the registered fetch output (IF/DE instruction register).
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q           <= StIdle;
            wptr_q            <= '0;
            cnt_q             <= '0;
            len_q             <= '0;
            instr_memory_data <= NOP_WORD;
            load_ready        <= 1'b0;
            core_hold         <= 1'b1;
            fetch_fault       <= 1'b0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (load_start) begin
                        if (load_len == 16'd0) begin
                            state_q   <= StRun;
                            core_hold <= 1'b0;
                        end else begin
                            state_q    <= StLoad;
                            len_q      <= len_clamped;
                            wptr_q     <= '0;
                            cnt_q      <= '0;
                            load_ready <= 1'b1;
                        end
                    end
                end
                StLoad: begin
                    if (accept) begin
                        wptr_q <= wptr_q + AW'(1);
                        cnt_q  <= cnt_q + 17'd1;
                        // Dropping ready on the same edge blocks any extra word.
                        if (last_word) begin
                            state_q    <= StRun;
                            load_ready <= 1'b0;
                            core_hold  <= 1'b0;
                        end
                    end
                end
                StRun: begin
                    // Only reset leaves RUN.
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase

            // Output register, in priority order.
            if (state_q != StRun) begin
                instr_memory_data <= NOP_WORD;
            end else if (instr_memory_flush) begin
                instr_memory_data <= NOP_WORD;
            end else if (!instr_memory_enable) begin
                instr_memory_data <= instr_memory_data;
            end else if (addr_misaligned || addr_out_of_range) begin
                instr_memory_data <= NOP_WORD;
                fetch_fault       <= 1'b1;
            end else begin
                instr_memory_data <= mem[rd_idx];
            end
        end
    end

endmodule

// File: doc/instr_memory_responder.md
Name: instr_memory_responder

Overview:
- Memory-side end of the core's instruction-fetch interface.
- Serves `instr_memory_addr`, `instr_memory_enable` and `instr_memory_flush`, and returns `instr_memory_data` through a registered output. That output register acts as the IF/DE instruction register: enable low holds it (stall), flush loads a bubble.
- Includes a word-streaming loader that fills the internal instruction RAM while the core is held in reset, then releases it.

Parameters:
- DEPTH_WORDS, 1024, instruction RAM depth in 32-bit words; power of two.
- NOP_WORD, 32'h0000_0013, encoding driven on flush, fault, or while not running.

Ports:
- clk  in  1  core clock.
- reset  in  1  synchronous, active-low reset.
- instr_memory_addr  in  32  byte address of the fetch, from the core.
- instr_memory_enable  in  1  1 = update the output register; 0 = hold (IF stall).
- instr_memory_flush  in  1  1 = output register loads NOP_WORD (DE clear).
- instr_memory_data  out  32  registered instruction word to the core.
- load_start  in  1  starts a load session; sampled in IDLE only.
- load_len  in  16  number of words to load; sampled with load_start.
- load_valid  in  1  load_data is valid this cycle.
- load_data  in  32  word to write.
- load_ready  out  1  responder accepts a word this cycle.
- core_hold  out  1  active-high reset for the core; 1 until RUN.
- fetch_fault  out  1  sticky; misaligned or out-of-range fetch seen.

Behaviour:
- All state changes on the rising edge of clk.
- When reset == 0 at an edge:
  - state = IDLE, wptr = 0, cnt = 0.
  - instr_memory_data = NOP_WORD, load_ready = 0, core_hold = 1, fetch_fault = 0.
  - RAM contents are untouched, including after a reset mid-load.
- State machine: IDLE, LOAD, RUN.
- IDLE:
  - load_start = 1 and load_len == 0 -> RUN, executing the existing RAM contents.
  - load_start = 1 and load_len > 0 -> LOAD. Capture len = min(load_len, DEPTH_WORDS); wptr = 0.
- LOAD:
  - load_ready = 1.
  - On load_valid && load_ready, write RAM[wptr] = load_data, then increment wptr and cnt.
  - Accepting the len-th word transitions to RUN on the same edge. load_ready deasserts the next cycle, so no extra word is accepted.
  - load_start is ignored in LOAD.
- RUN:
  - core_hold = 0 from the first cycle in RUN.
  - load_ready = 0; load_start is ignored. Only reset leaves RUN.
- core_hold is a registered output: 1 in IDLE and LOAD, 0 in RUN.
- Output register, evaluated in priority order each edge:
  1. State != RUN -> NOP_WORD.
  2. instr_memory_flush = 1 -> NOP_WORD. Flush wins over enable, and wins even when enable = 0.
  3. instr_memory_enable = 0 -> hold the previous value.
  4. instr_memory_addr[1:0] != 0, or word index addr[31:2] >= DEPTH_WORDS -> NOP_WORD and set fetch_fault.
  5. Otherwise -> RAM[addr[log2(DEPTH_WORDS)+1:2]].
- Read latency: 1 cycle. An address presented in cycle N is visible on instr_memory_data after edge N+1.
- RAM is single-port, synchronous read. Writes happen only in LOAD; reads happen only in RUN, so read/write collisions cannot occur.
- fetch_fault is cleared only by reset. A fault is not raised for a fetch that is flushed or stalled in the same cycle.
- wptr is a log2(DEPTH_WORDS)-bit counter. The len clamp guarantees it never wraps within a session.
- Simultaneous load_start and load_valid in IDLE: only load_start acts; the first word is accepted no earlier than the next cycle.

Test Plan:
- Reset, then load_start with load_len = 3 and words 0xA, 0xB, 0xC streamed with load_valid held high -> 3 writes accepted on consecutive edges. load_ready drops after the third; core_hold falls the cycle after the third accept.
- RUN, enable = 1, addresses 0, 4, 8 on consecutive cycles -> instr_memory_data = 0xA, 0xB, 0xC, each one cycle after its address; fetch_fault = 0.
- RUN, enable = 0 for 2 cycles while addr changes to 4 -> data holds at 0xA. With flush = 1 and enable = 0 -> data = 0x00000013 on the next edge.
- RUN, addr = 0x2 -> data = NOP_WORD and fetch_fault = 1 (sticky). Then addr = 4 -> data = 0xB and fetch_fault stays 1. addr = DEPTH_WORDS*4 also faults.
- Load with load_len = 5, gaps in load_valid, and reset asserted after 2 words -> IDLE, core_hold = 1, data = NOP_WORD. A re-load with load_len = 0 enters RUN, and addr 4 returns the second word written before the reset.
- load_len = 0xFFFF with DEPTH_WORDS = 16 -> exactly 16 words accepted, then RUN; a 17th load_valid is not accepted (load_ready = 0).
